// File: rtl/orde_resp_arb.sv
// orde_resp_arb: round-robin arbiter that merges NUM_REQ channel read-response
// streams into the single ordering-buffer response input.
//
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   in_valid/in_rdy per-requester beat handshake (in_rdy = skid FIFO not full)
//   in_meta/in_data per-requester beat payload, requester i at [i*W +: W]
//   in_last         beat closes its burst (1 for single-beat responses)
//   out_valid/rdy   registered output beat handshake towards the buffer
//   out_meta/data   registered copy of the granted beat
//   out_ch/out_last granted requester index and its last flag
//   arb_locked      grant held by an unfinished multi-beat burst
module orde_resp_arb #(
    parameter int NUM_REQ    = 4,
    parameter int META_W     = 48,
    parameter int DATA_W     = 256,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         in_valid,
    output logic [NUM_REQ-1:0]         in_rdy,
    input  logic [NUM_REQ*META_W-1:0]  in_meta,
    input  logic [NUM_REQ*DATA_W-1:0]  in_data,
    input  logic [NUM_REQ-1:0]         in_last,
    output logic                       out_valid,
    output logic [META_W-1:0]          out_meta,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(NUM_REQ)-1:0] out_ch,
    output logic                       out_last,
    input  logic                       out_rdy,
    output logic                       arb_locked
);

    localparam int CHW = $clog2(NUM_REQ);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    // Skid FIFO storage, one ring per requester.
    logic [META_W-1:0] fifo_meta [NUM_REQ][FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [NUM_REQ][FIFO_DEPTH];
    logic              fifo_last [NUM_REQ][FIFO_DEPTH];

    logic [PW-1:0] wr_ptr [NUM_REQ];
    logic [PW-1:0] rd_ptr [NUM_REQ];
    logic [CW-1:0] cnt    [NUM_REQ];

    logic [NUM_REQ-1:0] push;
    logic [NUM_REQ-1:0] pop;
    logic [NUM_REQ-1:0] full;
    logic [NUM_REQ-1:0] not_empty;

    logic [META_W-1:0] head_meta [NUM_REQ];
    logic [DATA_W-1:0] head_data [NUM_REQ];
    logic              head_last [NUM_REQ];

    state_t         state;
    logic [CHW-1:0] rr_ptr;
    logic [CHW-1:0] lock_ch;

    logic           win_vld;
    logic [CHW-1:0] win_idx;
    logic [CHW-1:0] scan;
    logic           load_en;
    logic           load;

    function automatic logic [CHW-1:0] nxt_ch(input logic [CHW-1:0] c);
        return (c == CHW'(NUM_REQ - 1)) ? '0 : c + CHW'(1);
    endfunction

    // Full/empty come from registered occupancy only, so a pop in the
    // same cycle never opens room for a push.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            full[i]      = (cnt[i] == CW'(FIFO_DEPTH));
            not_empty[i] = (cnt[i] != '0);
            push[i]      = in_valid[i] && !full[i];
            head_meta[i] = fifo_meta[i][rd_ptr[i]];
            head_data[i] = fifo_data[i][rd_ptr[i]];
            head_last[i] = fifo_last[i][rd_ptr[i]];
        end
    end

    assign in_rdy = ~full;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (push[i]) begin
                fifo_meta[i][wr_ptr[i]] <= in_meta[i*META_W +: META_W];
                fifo_data[i][wr_ptr[i]] <= in_data[i*DATA_W +: DATA_W];
                fifo_last[i][wr_ptr[i]] <= in_last[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PW'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PW'(1);
                end
                unique case ({push[i], pop[i]})
                    2'b10:   cnt[i] <= cnt[i] + CW'(1);
                    2'b01:   cnt[i] <= cnt[i] - CW'(1);
                    default: cnt[i] <= cnt[i];
                endcase
            end
        end
    end

    // Winner select. While locked only the burst owner may win, even if
    // its FIFO is momentarily empty; that produces a bubble rather than
    // letting another requester interleave into the burst.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        scan    = rr_ptr;
        if (state == LOCKED) begin
            win_vld = not_empty[lock_ch];
            win_idx = lock_ch;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!win_vld && not_empty[scan]) begin
                    win_vld = 1'b1;
                    win_idx = scan;
                end
                scan = nxt_ch(scan);
            end
        end
    end

    assign load_en = !out_valid || out_rdy;
    assign load    = load_en && win_vld;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            pop[i] = load && (win_idx == CHW'(i));
        end
    end

    // Output register and grant FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_meta  <= '0;
            out_data  <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
            rr_ptr    <= '0;
            lock_ch   <= '0;
            state     <= IDLE;
        end else if (load) begin
            out_valid <= 1'b1;
            out_meta  <= head_meta[win_idx];
            out_data  <= head_data[win_idx];
            out_ch    <= win_idx;
            out_last  <= head_last[win_idx];
            if (head_last[win_idx]) begin
                rr_ptr <= nxt_ch(win_idx);
                state  <= IDLE;
            end else begin
                lock_ch <= win_idx;
                state   <= LOCKED;
            end
        end else if (out_rdy) begin
            out_valid <= 1'b0;
        end
    end

    assign arb_locked = (state == LOCKED);

endmodule

// File: tb/tb_orde_resp_arb.sv
// tb_orde_resp_arb: directed self-checking bench for orde_resp_arb.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_orde_resp_arb;

    localparam int N   = 4;
    localparam int MW  = 48;
    localparam int DW  = 256;
    localparam int CHW = 2;
    localparam int BW  = 1 + CHW + MW + DW + 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      in_valid;
    logic [N-1:0]      in_rdy;
    logic [N*MW-1:0]   in_meta;
    logic [N*DW-1:0]   in_data;
    logic [N-1:0]      in_last;
    logic              out_valid;
    logic [MW-1:0]     out_meta;
    logic [DW-1:0]     out_data;
    logic [CHW-1:0]    out_ch;
    logic              out_last;
    logic              out_rdy;
    logic              arb_locked;

    int total = 0;
    int bad   = 0;

    logic [BW-1:0] obs;
    logic [BW-1:0] exp;

    orde_resp_arb #(
        .NUM_REQ(N), .META_W(MW), .DATA_W(DW), .FIFO_DEPTH(2)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_rdy(in_rdy),
        .in_meta(in_meta), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_meta(out_meta), .out_data(out_data),
        .out_ch(out_ch), .out_last(out_last), .out_rdy(out_rdy),
        .arb_locked(arb_locked)
    );

    always #5 clk = ~clk;

    function automatic logic [MW-1:0] mk_meta(int i, int s);
        return {16'hBEEF, 8'(i), 8'(s), 16'h0F0F};
    endfunction

    function automatic logic [DW-1:0] mk_data(int i, int s);
        return {8{16'hA5C3, 8'(i), 8'(s)}};
    endfunction

    function automatic logic [BW-1:0] beat(int i, int s, logic l, logic lk);
        return {1'b1, CHW'(i), mk_meta(i, s), mk_data(i, s), l, lk};
    endfunction

    function automatic logic [BW-1:0] cur();
        return {out_valid, out_ch, out_meta, out_data, out_last, arb_locked};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(int i, logic [MW-1:0] m, logic [DW-1:0] d, logic l);
        in_valid[i]         = 1'b1;
        in_meta[i*MW +: MW] = m;
        in_data[i*DW +: DW] = d;
        in_last[i]          = l;
    endtask

    task automatic idle_in();
        in_valid = '0;
        in_last  = '0;
    endtask

    task automatic apply_reset();
        idle_in();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        idle_in();
        in_meta = '0;
        in_data = '0;
        out_rdy = 1'b1;
        rst     = 1'b1;
        tick();
        tick();
        total++;
        if (cur() !== '0) begin
            bad++;
            $display("FAIL reset_out got=%h exp=0", cur());
        end
        total++;
        if (in_rdy !== 4'hF) begin
            bad++;
            $display("FAIL reset_in_rdy got=%h exp=f", in_rdy);
        end
        rst = 1'b0;
        tick();
        total++;
        if (out_valid !== 1'b0 || arb_locked !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle got=%b%b exp=00", out_valid, arb_locked);
        end
    endtask

    task automatic test_single();
        logic [MW-1:0] m;
        logic [DW-1:0] d;
        m = 48'h0000_1234_0001;
        d = {32{8'hA5}};
        out_rdy = 1'b1;
        drive(2, m, d, 1'b1);
        tick();
        idle_in();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_t1 got=%b exp=0", out_valid);
        end
        tick();
        exp = {1'b1, 2'd2, m, d, 1'b1, 1'b0};
        total++;
        if (cur() !== exp) begin
            bad++;
            $display("FAIL single_t2 got=%h exp=%h", cur(), exp);
        end
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_drain got=%b exp=0", out_valid);
        end
        // rr_ptr is now 3: with req0 and req3 both pending, req3 goes first.
        drive(0, mk_meta(0, 1), mk_data(0, 1), 1'b1);
        drive(3, mk_meta(3, 1), mk_data(3, 1), 1'b1);
        tick();
        idle_in();
        tick();
        exp = beat(3, 1, 1'b1, 1'b0);
        total++;
        if (cur() !== exp) begin
            bad++;
            $display("FAIL rr_after_single_a got=%h exp=%h", cur(), exp);
        end
        tick();
        exp = beat(0, 1, 1'b1, 1'b0);
        total++;
        if (cur() !== exp) begin
            bad++;
            $display("FAIL rr_after_single_b got=%h exp=%h", cur(), exp);
        end
        tick();
    endtask

    task automatic test_round_robin();
        apply_reset();
        out_rdy = 1'b1;
        for (int i = 0; i < N; i++) drive(i, mk_meta(i, 0), mk_data(i, 0), 1'b1);
        tick();
        for (int i = 0; i < N; i++) drive(i, mk_meta(i, 1), mk_data(i, 1), 1'b1);
        tick();
        idle_in();
        for (int k = 0; k < 8; k++) begin
            exp = beat(k % 4, k / 4, 1'b1, 1'b0);
            total++;
            if (cur() !== exp) begin
                bad++;
                $display("FAIL rr_seq k=%0d got=%h exp=%h", k, cur(), exp);
            end
            tick();
        end
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rr_end got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_burst_lock();
        out_rdy = 1'b1;
        drive(0, mk_meta(0, 9), mk_data(0, 9), 1'b1);
        tick();
        idle_in();
        tick();
        tick();
        // rr_ptr = 1 now.
        drive(1, mk_meta(1, 0), mk_data(1, 0), 1'b0);
        drive(0, mk_meta(0, 1), mk_data(0, 1), 1'b1);
        drive(3, mk_meta(3, 1), mk_data(3, 1), 1'b1);
        tick();
        idle_in();
        drive(1, mk_meta(1, 1), mk_data(1, 1), 1'b0);
        tick();
        idle_in();
        drive(1, mk_meta(1, 2), mk_data(1, 2), 1'b1);
        exp = beat(1, 0, 1'b0, 1'b1);
        total++;
        if (cur() !== exp) begin
            bad++;
            $display("FAIL burst_b0 got=%h exp=%h", cur(), exp);
        end
        tick();
        idle_in();
        exp = beat(1, 1, 1'b0, 1'b1);
        total++;
        if (cur() !== exp) begin
            bad++;
            $display("FAIL burst_b1 got=%h exp=%h", cur(), exp);
        end
        tick();
        exp = beat(1, 2, 1'b1, 1'b0);
        total++;
        if (cur() !== exp) begin
            bad++;
            $display("FAIL burst_b2 got=%h exp=%h", cur(), exp);
        end
        tick();
        exp = beat(3, 1, 1'b1, 1'b0);
        total++;
        if (cur() !== exp) begin
            bad++;
            $display("FAIL burst_next3 got=%h exp=%h", cur(), exp);
        end
        tick();
        exp = beat(0, 1, 1'b1, 1'b0);
        total++;
        if (cur() !== exp) begin
            bad++;
            $display("FAIL burst_next0 got=%h exp=%h", cur(), exp);
        end
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL burst_end got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_locked_empty();
        // rr_ptr = 1 entering this test.
        out_rdy = 1'b1;
        drive(1, mk_meta(1, 5), mk_data(1, 5), 1'b0);
        drive(2, mk_meta(2, 5), mk_data(2, 5), 1'b1);
        tick();
        idle_in();
        tick();
        exp = beat(1, 5, 1'b0, 1'b1);
        total++;
        if (cur() !== exp) begin
            bad++;
            $display("FAIL lockemp_b0 got=%h exp=%h", cur(), exp);
        end
        for (int c = 3; c <= 5; c++) begin
            tick();
            if (c == 4) drive(1, mk_meta(1, 6), mk_data(1, 6), 1'b1);
            if (c == 5) idle_in();
            total++;
            if (out_valid !== 1'b0 || arb_locked !== 1'b1) begin
                bad++;
                $display("FAIL lockemp_bubble c=%0d got=%b%b exp=01",
                         c, out_valid, arb_locked);
            end
        end
        tick();
        exp = beat(1, 6, 1'b1, 1'b0);
        total++;
        if (cur() !== exp) begin
            bad++;
            $display("FAIL lockemp_b1 got=%h exp=%h", cur(), exp);
        end
        tick();
        exp = beat(2, 5, 1'b1, 1'b0);
        total++;
        if (cur() !== exp) begin
            bad++;
            $display("FAIL lockemp_req2 got=%h exp=%h", cur(), exp);
        end
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL lockemp_end got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        int  sent;
        int  got;
        logic acc;
        sent = 0;
        got  = 0;
        for (int c = 0; c < 24; c++) begin
            out_rdy = (c >= 5);
            idle_in();
            if (sent < 6) drive(0, mk_meta(0, sent), mk_data(0, sent), 1'b1);
            acc = in_valid[0] && in_rdy[0];
            if (c >= 2 && c <= 4) begin
                exp = beat(0, 0, 1'b1, 1'b0);
                total++;
                if (cur() !== exp) begin
                    bad++;
                    $display("FAIL bp_stable c=%0d got=%h exp=%h", c, cur(), exp);
                end
            end
            if (c == 3 || c == 4) begin
                total++;
                if (in_rdy[0] !== 1'b0) begin
                    bad++;
                    $display("FAIL bp_in_rdy c=%0d got=%b exp=0", c, in_rdy[0]);
                end
            end
            if (out_valid && out_rdy) begin
                exp = beat(0, got, 1'b1, 1'b0);
                total++;
                if (cur() !== exp) begin
                    bad++;
                    $display("FAIL bp_order n=%0d got=%h exp=%h", got, cur(), exp);
                end
                got++;
            end
            tick();
            if (acc) sent++;
        end
        idle_in();
        total++;
        if (got != 6 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_count got=%0d/%b exp=6/0", got, out_valid);
        end
    endtask

    task automatic test_reset_mid_burst();
        out_rdy = 1'b1;
        drive(1, mk_meta(1, 7), mk_data(1, 7), 1'b0);
        drive(2, mk_meta(2, 7), mk_data(2, 7), 1'b1);
        tick();
        idle_in();
        drive(1, mk_meta(1, 8), mk_data(1, 8), 1'b0);
        tick();
        idle_in();
        drive(1, mk_meta(1, 9), mk_data(1, 9), 1'b1);
        out_rdy = 1'b0;
        tick();
        idle_in();
        total++;
        if (arb_locked !== 1'b1 || in_rdy !== 4'b1101) begin
            bad++;
            $display("FAIL rstmid_pre got=%b/%h exp=1/d", arb_locked, in_rdy);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (cur() !== '0 || in_rdy !== 4'hF) begin
            bad++;
            $display("FAIL rstmid_async got=%h/%h exp=0/f", cur(), in_rdy);
        end
        tick();
        rst = 1'b0;
        out_rdy = 1'b1;
        tick();
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_flushed got=%b exp=0", out_valid);
        end
        drive(0, mk_meta(0, 3), mk_data(0, 3), 1'b1);
        drive(3, mk_meta(3, 3), mk_data(3, 3), 1'b1);
        tick();
        idle_in();
        tick();
        exp = beat(0, 3, 1'b1, 1'b0);
        total++;
        if (cur() !== exp) begin
            bad++;
            $display("FAIL rstmid_first got=%h exp=%h", cur(), exp);
        end
        tick();
        exp = beat(3, 3, 1'b1, 1'b0);
        total++;
        if (cur() !== exp) begin
            bad++;
            $display("FAIL rstmid_second got=%h exp=%h", cur(), exp);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_burst_lock();
        test_locked_empty();
        test_backpressure();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
